regfile_mp: RTL and testbench

- Parametrised multi-port register file for the RISC-V core. Successor to the single-write, two-read file.
- Provides NUM_RD combinational read ports, two clocked write ports with fixed priority, and an optional write-to-read bypass.
- Holds a per-register busy (scoreboard) bit so decode can detect operands still pending from in-flight producers.
- Sits between decode (reads, busy set) and writeback (writes, busy clear).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// write ports (wr1 wins), optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     busy_set_en,
   input  logic [ADDR_W-1:0]        busy_set_addr,
   output logic [NUM_REGS-1:0]      busy
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busyQ;
   logic                wr0Commit;
   logic                wr1Commit;
   logic                setValid;

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(NUM_REGS);
   endfunction

   // Register 0 is excluded from writes and busy-set when it is hardwired to zero.
   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return inRange(a) && !(ZERO_REG != 0 && a == '0);
   endfunction

   assign wr0Commit = wr0_en && writable(wr0_addr);
   assign wr1Commit = wr1_en && writable(wr1_addr);
   assign setValid  = busy_set_en && writable(busy_set_addr);

   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (reset) begin
            regs[r]  <= '0;
            busyQ[r] <= 1'b0;
         end else begin
            if (wr1Commit && wr1_addr == ADDR_W'(r))
               regs[r] <= wr1_data;
            else if (wr0Commit && wr0_addr == ADDR_W'(r))
               regs[r] <= wr0_data;
            // A newly issued producer outranks a retiring one on the same register.
            if (setValid && busy_set_addr == ADDR_W'(r))
               busyQ[r] <= 1'b1;
            else if ((wr1Commit && wr1_addr == ADDR_W'(r)) ||
                     (wr0Commit && wr0_addr == ADDR_W'(r)))
               busyQ[r] <= 1'b0;
         end
      end
   end

   assign busy = busyQ;

   for (genvar i = 0; i < NUM_RD; i++) begin : gRd
      logic [ADDR_W-1:0] rdA;
      logic [DATA_W-1:0] rdD;
      logic              rdB;

      assign rdA = rd_addr[i*ADDR_W +: ADDR_W];

      always_comb begin
         rdD = '0;
         rdB = 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            if (rdA == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0)) begin
               rdD = regs[r];
               rdB = busyQ[r];
            end
         end
         // Forwarded data is by definition no longer pending.
         if (BYPASS != 0) begin
            if (wr0Commit && wr0_addr == rdA) begin
               rdD = wr0_data;
               rdB = 1'b0;
            end
            if (wr1Commit && wr1_addr == rdA) begin
               rdD = wr1_data;
               rdB = 1'b0;
            end
         end
      end

      assign rd_data[i*DATA_W +: DATA_W] = rdD;
      assign rd_busy[i]                  = rdB;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (zero reg, bypass, 2 reads)
// and a wide instance (no zero reg, no bypass, 4 reads, 6-bit addresses).
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        aWr0En, aWr1En, aSetEn;
   logic [4:0]  aWr0Addr, aWr1Addr, aSetAddr;
   logic [31:0] aWr0Data, aWr1Data;
   logic [9:0]  aRdAddr;
   logic [63:0] aRdData;
   logic [1:0]  aRdBusy;
   logic [31:0] aBusy;

   logic         bWr0En, bWr1En, bSetEn;
   logic [5:0]   bWr0Addr, bWr1Addr, bSetAddr;
   logic [31:0]  bWr0Data, bWr1Data;
   logic [23:0]  bRdAddr;
   logic [127:0] bRdData;
   logic [3:0]   bRdBusy;
   logic [31:0]  bBusy;

   int nCmp = 0;
   int nBad = 0;

   regfile_mp dutA (
      .clk(clk), .reset(reset),
      .wr0_en(aWr0En), .wr0_addr(aWr0Addr), .wr0_data(aWr0Data),
      .wr1_en(aWr1En), .wr1_addr(aWr1Addr), .wr1_data(aWr1Data),
      .rd_addr(aRdAddr), .rd_data(aRdData), .rd_busy(aRdBusy),
      .busy_set_en(aSetEn), .busy_set_addr(aSetAddr), .busy(aBusy)
   );

   regfile_mp #(
      .DATA_W(32), .NUM_REGS(32), .ADDR_W(6), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)
   ) dutB (
      .clk(clk), .reset(reset),
      .wr0_en(bWr0En), .wr0_addr(bWr0Addr), .wr0_data(bWr0Data),
      .wr1_en(bWr1En), .wr1_addr(bWr1Addr), .wr1_data(bWr1Data),
      .rd_addr(bRdAddr), .rd_data(bRdData), .rd_busy(bRdBusy),
      .busy_set_en(bSetEn), .busy_set_addr(bSetAddr), .busy(bBusy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      aWr0En = 0; aWr1En = 0; aSetEn = 0;
      bWr0En = 0; bWr1En = 0; bSetEn = 0;
   endtask

   initial begin
      idle();
      aWr0Addr = 0; aWr1Addr = 0; aSetAddr = 0; aWr0Data = 0; aWr1Data = 0; aRdAddr = 0;
      bWr0Addr = 0; bWr1Addr = 0; bSetAddr = 0; bWr0Data = 0; bWr1Data = 0; bRdAddr = 0;

      // Reset and sweep every address.
      reset = 1;
      tick();
      for (int a = 0; a < 32; a++) begin
         aRdAddr = {5'(a), 5'(a)};
         #1 check("rst_read_all", aRdData, 0);
      end
      check("rst_busyA", aBusy, 0);
      check("rst_busyB", bBusy, 0);
      bRdAddr = {6'd40, 6'd31, 6'd0, 6'd1};
      #1 check("rst_readB", bRdData, 0);
      reset = 0;

      // Plain write, then reset overriding a concurrent write.
      aWr0En = 1; aWr0Addr = 5; aWr0Data = 32'hDEADBEEF;
      tick(); idle();
      aRdAddr = {5'd0, 5'd5};
      #1 check("wr_x5", aRdData[31:0], 32'hDEADBEEF);
      reset = 1; aWr0En = 1; aWr0Addr = 6; aWr0Data = 32'h12345678;
      tick(); reset = 0; idle();
      aRdAddr = {5'd6, 5'd5};
      #1 check("rst_over_wr", aRdData, 0);

      // Both ports to x7: wr1 wins, also through the bypass.
      aWr0En = 1; aWr0Addr = 7; aWr0Data = 32'h11111111;
      aWr1En = 1; aWr1Addr = 7; aWr1Data = 32'h22222222;
      aRdAddr = {5'd8, 5'd7};
      #1 check("bypass_prio", aRdData[31:0], 32'h22222222);
      check("bypass_other_port", aRdData[63:32], 0);
      tick(); idle();
      #1 check("wr_prio_x7", aRdData[31:0], 32'h22222222);

      // Hardwired zero register.
      aWr0En = 1; aWr0Addr = 0; aWr0Data = 32'hFFFFFFFF;
      aSetEn = 1; aSetAddr = 0; aRdAddr = {5'd0, 5'd0};
      #1 check("x0_no_bypass", aRdData, 0);
      tick(); idle();
      #1 check("x0_read", aRdData, 0);
      check("x0_busy", aBusy[0], 0);

      // Scoreboard set, bypassed clear.
      aSetEn = 1; aSetAddr = 3;
      tick(); idle();
      aRdAddr = {5'd3, 5'd3};
      #1 check("busy3_set", aBusy[3], 1);
      check("rd_busy3", aRdBusy, 2'b11);
      aWr0En = 1; aWr0Addr = 3; aWr0Data = 32'h5;
      #1 check("rd_busy3_fwd", aRdBusy, 2'b00);
      check("rd_data3_fwd", aRdData, {32'h5, 32'h5});
      tick(); idle();
      #1 check("busy_cleared", aBusy, 0);
      check("x3_stored", aRdData, {32'h5, 32'h5});

      // Set beats clear on the same register.
      aSetEn = 1; aSetAddr = 9; aWr1En = 1; aWr1Addr = 9; aWr1Data = 32'hA;
      tick(); idle();
      aRdAddr = {5'd9, 5'd9};
      #1 check("set_wins_busy", aBusy, 32'h200);
      check("set_wins_data", aRdData[31:0], 32'hA);
      check("set_wins_rdbusy", aRdBusy, 2'b11);

      // Two distinct writes commit together.
      aWr0En = 1; aWr0Addr = 10; aWr0Data = 32'hAA;
      aWr1En = 1; aWr1Addr = 11; aWr1Data = 32'hBB;
      tick(); idle();
      aRdAddr = {5'd11, 5'd10};
      #1 check("dual_write", aRdData, {32'hBB, 32'hAA});

      // Wide instance: x0 is an ordinary register.
      bWr0En = 1; bWr0Addr = 0; bWr0Data = 32'hFFFFFFFF;
      tick(); idle();
      bRdAddr = {6'd0, 6'd0, 6'd0, 6'd0};
      #1 check("b_x0_read", bRdData[31:0], 32'hFFFFFFFF);
      bSetEn = 1; bSetAddr = 0;
      tick(); idle();
      #1 check("b_x0_busy", bBusy, 32'h1);
      check("b_x0_rdbusy", bRdBusy, 4'hF);

      // Four ports, no bypass: new data one cycle later.
      bWr0En = 1; bWr0Addr = 1; bWr0Data = 32'h10;
      bWr1En = 1; bWr1Addr = 2; bWr1Data = 32'h20;
      tick();
      bWr0Addr = 3; bWr0Data = 32'h30;
      bWr1Addr = 4; bWr1Data = 32'h40;
      tick(); idle();
      bRdAddr = {6'd4, 6'd3, 6'd2, 6'd1};
      #1 check("b_four_ports", bRdData, {32'h40, 32'h30, 32'h20, 32'h10});
      bWr0En = 1; bWr0Addr = 2; bWr0Data = 32'h33;
      #1 check("b_no_bypass", bRdData[63:32], 32'h20);
      tick(); idle();
      #1 check("b_after_edge", bRdData, {32'h40, 32'h30, 32'h33, 32'h10});

      // Out-of-range address: reads 0, writes and busy-set ignored, no aliasing.
      bRdAddr = {6'd8, 6'd40, 6'd40, 6'd40};
      bWr0En = 1; bWr0Addr = 40; bWr0Data = 32'h99;
      bSetEn = 1; bSetAddr = 40;
      #1 check("b_oob_read", bRdData, 0);
      tick(); idle();
      #1 check("b_oob_after", bRdData, 0);
      check("b_oob_busy", bBusy, 32'h1);

      // Without bypass, rd_busy stays up until the edge.
      bSetEn = 1; bSetAddr = 5;
      tick(); idle();
      bRdAddr = {6'd0, 6'd0, 6'd0, 6'd5};
      bWr0En = 1; bWr0Addr = 5; bWr0Data = 32'h55;
      #1 check("b_busy_held", bRdBusy[0], 1);
      check("b_data_held", bRdData[31:0], 0);
      tick(); idle();
      #1 check("b_busy_clr", bRdBusy[0], 0);
      check("b_data_new", bRdData[31:0], 32'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
